adf4350_loader: RTL and testbench
=================================

# adf4350_loader

Serial-bus-programmed SPI master for the ADF4350 wideband synthesizer (the VCO on the WSA1000 front end). It holds six shadow copies of the synthesizer's 32-bit registers, written via the FPGA serial register bus, and shifts them out on a dedicated 3-wire bus when commanded. It also qualifies the synthesizer MUXOUT lock-detect and reports loader status on a readback word. It sits between `serial_io` (the consumer of `serial_strobe`, `serial_addr` and `serial_data`) and the VCO pins `VCO_LE` and `VCO_MUXOUT`, plus the SCLK/SDATA pair routed to `PROTO_PORT`. It runs in the `adcclk` domain alongside `master_control`.

## Interface
- `BASE_ADDR`, default 7'd96: serial address of shadow R0. R0..R5 occupy BASE_ADDR..BASE_ADDR+5; the control register is BASE_ADDR+6.
- `CLK_DIV`, default 4: SCLK half-period in `clock` cycles. Legal range is 1..255.
- `LOCK_CNT`, default 1024: number of consecutive synchronized-high MUXOUT cycles required to declare lock.

- `clock` in 1: adcclk, 50 MHz. This is the single clock.
- `reset` in 1: asynchronous, active-high.
- `serial_strobe` in 1: one-cycle write strobe, already synchronous to `clock`.
- `serial_addr` in 7: register address.
- `serial_data` in 32: write data.
- `vco_muxout` in 1: raw lock-detect pin, asynchronous.
- `vco_sclk` out 1: SPI clock, idles low.
- `vco_sdata` out 1: SPI data, MSB first.
- `vco_le` out 1: load-enable pulse, active high.
- `busy` out 1: high while any register is pending or shifting.
- `locked` out 1: qualified lock.
- `status` out 32: readback word, layout given under Operation.

## Operation
- **Shadow writes.** A strobe at BASE_ADDR+k (k = 0..5) stores `serial_data` into shadow Rk, with bits [2:0] forced to k. Writes are accepted at any time, including while busy.
- **Control write.** A strobe at BASE_ADDR+6:
  - bits [5:0] are ORed into the `pending` mask;
  - bit 31 clears the sticky unlock flag.
- **Service order.** The highest pending index is serviced first, so a mask of 6'h3F loads R5, R4, ..., R0 (the ADF4350's required order).
- **States.** IDLE → LOAD → SHIFT → LE_SETUP → LE_PULSE → GAP → (LOAD if pending is nonzero, else IDLE).
  - LOAD, 1 cycle: copies the selected shadow into the shift register and clears that bit in `pending`. Later shadow writes do not affect the word in flight.
  - SHIFT, 32 bits: `vco_sdata` updates while SCLK is low. SCLK is high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - LE_SETUP: CLK_DIV cycles with SCLK low.
  - LE_PULSE: `vco_le` is high for CLK_DIV cycles.
  - GAP: CLK_DIV cycles with everything low.
- **Simultaneous events.** If a control strobe arrives in the same cycle as a LOAD clears a bit, the OR with the new mask wins, so the register is re-queued.
- **Load counter.** `load_count` (8 bits) increments on each LE_PULSE entry and wraps from 255 to 0.
- **Status word.**
  - [5:0] `pending`
  - [13:6] `load_count`
  - [14] `locked`
  - [15] `sticky_unlock`
  - [16] `busy`
  - [31:17] 0

## Timing
- **Reset values.** All outputs, `pending`, shadows, `load_count`, the lock counter and the sticky flag are 0. The state is IDLE.
- **Reset mid-shift.** Outputs drop to 0 asynchronously. No LE pulse is issued.
- **Command latency.** A control strobe in cycle n puts the machine in LOAD at n+1. The first `vco_sdata` bit is valid at n+2, and the first SCLK rise is at n+2+CLK_DIV.
- **Per-register time.** 1 + 67·CLK_DIV cycles, which is 269 cycles at the default CLK_DIV.
- **Busy.** `busy` rises the cycle after the strobe. It falls in the cycle IDLE is re-entered.
- **Bus timing.** `vco_sdata` is stable for at least CLK_DIV cycles on either side of each SCLK rising edge. LE rises at least CLK_DIV cycles after the last SCLK fall.
- **Lock qualification.** `vco_muxout` passes through a 2-FF synchronizer.
  - `locked` rises after LOCK_CNT consecutive high samples.
  - It falls in the cycle after any low sample, and that cycle also sets `sticky_unlock`.

## Configuration
- **With `VCO_LOCK_DETECT_EN` defined:** the synchronizer, lock counter, `locked` and `sticky_unlock` are built as described above.
- **Without `VCO_LOCK_DETECT_EN`:** `vco_muxout` is ignored, `locked` = 0, and status[15:14] = 0. The shift path is unchanged.

## Structure
- **Shared package:** register offset constants (R0..R5 and CTRL = 6), the state encoding, and the status bit positions.
- **Sub-module `vco_lock_filter`:** the synchronizer plus saturating counter. Parameter is LOCK_CNT; outputs are `locked` and an unlock pulse. It is instantiated only under the macro.

## Test plan
- **R0 single load.** Write R0 = 32'h00A5_5A28, then control = 6'h01. Expected: 32 SCLK pulses; sampled data 32'h00A5_5A28 (bits [2:0] = 000); one LE pulse; `load_count` = 1; `busy` low after 269 cycles.
- **Full sequence.** Write all shadows, then control = 6'h3F. Expected: six words in order R5..R0, each carrying control bits 101..000; `load_count` = 6.
- **Re-queue and isolation.** While R3 is shifting, rewrite R3 and issue control = 6'h08. Expected: the in-flight word keeps its old value, and R3 is sent again with the new value afterwards.
- **Reset mid-operation.** Assert reset during bit 17. Expected: SCLK, SDATA and LE are 0 immediately; no LE pulse; `pending` = 0; `status` = 0.
- **Lock detect (with macro).** Drive MUXOUT high for LOCK_CNT + 3 cycles, then low for 1 cycle. Expected: `locked` rises, then falls; `sticky_unlock` = 1. A control write with bit 31 set clears it.
- **Macro off.** Toggle MUXOUT. Expected: `locked` and status[15:14] stay 0.

Source files
------------

// File: rtl/adf4350_loader_pkg.sv
// adf4350_loader shared definitions: register offsets,
// loader state encoding and status word bit positions.
package adf4350_loader_pkg;

    localparam int unsigned REG_R0   = 0;
    localparam int unsigned REG_R1   = 1;
    localparam int unsigned REG_R2   = 2;
    localparam int unsigned REG_R3   = 3;
    localparam int unsigned REG_R4   = 4;
    localparam int unsigned REG_R5   = 5;
    localparam int unsigned REG_CTRL = 6;
    localparam int unsigned NUM_REGS = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LE_SETUP,
        ST_LE_PULSE,
        ST_GAP
    } state_t;

    localparam int unsigned STAT_PEND_LSB  = 0;
    localparam int unsigned STAT_COUNT_LSB = 6;
    localparam int unsigned STAT_LOCKED    = 14;
    localparam int unsigned STAT_STICKY    = 15;
    localparam int unsigned STAT_BUSY      = 16;

    function automatic logic [2:0] top_index(input logic [5:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 6; i++)
            if (m[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/adf4350_loader_lock.sv
// MUXOUT lock qualifier: 2-FF synchronizer and saturating
// run-length counter of consecutive high samples.
module vco_lock_filter #(
    parameter int unsigned LOCK_CNT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic vco_muxout,
    output logic locked,
    output logic unlock_pulse
);

    localparam int unsigned W = $clog2(LOCK_CNT + 1);

    logic         sync1;
    logic         sync2;
    logic [W-1:0] run_cnt;

    // bring the asynchronous pin into the clock domain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= vco_muxout;
            sync2 <= sync1;
        end
    end

    // count consecutive highs; any low sample drops lock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
            locked  <= 1'b0;
        end else if (!sync2) begin
            run_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            if (run_cnt != W'(LOCK_CNT))
                run_cnt <= run_cnt + 1'b1;
            if (run_cnt == W'(LOCK_CNT - 1))
                locked <= 1'b1;
        end
    end

    assign unlock_pulse = locked & ~sync2;

endmodule

// File: rtl/adf4350_loader.sv
// ADF4350 shadow-register SPI loader with optional lock
// detect (build with VCO_LOCK_DETECT_EN to enable it).
import adf4350_loader_pkg::*;

module adf4350_loader #(
    parameter logic [6:0]  BASE_ADDR = 7'd96,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned LOCK_CNT  = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_strobe,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        vco_muxout,
    output logic        vco_sclk,
    output logic        vco_sdata,
    output logic        vco_le,
    output logic        busy,
    output logic        locked,
    output logic [31:0] status
);

    state_t      state;
    logic [31:0] shadow [NUM_REGS];
    logic [5:0]  pending;
    logic [5:0]  pend_next;
    logic [5:0]  set_mask;
    logic [5:0]  clr_mask;
    logic [2:0]  sel;
    logic [31:0] cur_word;
    logic [31:0] sreg;
    logic [4:0]  bit_cnt;
    logic [7:0]  div_cnt;
    logic        div_end;
    logic [7:0]  load_count;
    logic        sticky_unlock;
    logic        ctrl_hit;

    assign ctrl_hit = serial_strobe &&
                      serial_addr == BASE_ADDR + 7'(REG_CTRL);
    assign set_mask = ctrl_hit ? serial_data[5:0] : 6'd0;
    assign sel      = top_index(pending);
    assign cur_word = shadow[sel];
    assign div_end  = (div_cnt == 8'(CLK_DIV - 1));

    // the register being loaded leaves the mask; a new
    // command in the same cycle re-queues it
    always_comb begin
        clr_mask = '0;
        if (state == ST_LOAD)
            clr_mask = 6'd1 << sel;
        pend_next = (pending & ~clr_mask) | set_mask;
    end

    // shadow writes, control bits forced to the index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++)
                shadow[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                if (serial_strobe &&
                    serial_addr == BASE_ADDR + 7'(k))
                    shadow[k] <= {serial_data[31:3], 3'(k)};
        end
    end

    // load sequencer with registered bus outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pending    <= '0;
            sreg       <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            load_count <= '0;
            vco_sclk   <= 1'b0;
            vco_sdata  <= 1'b0;
            vco_le     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pending <= pend_next;
            unique case (state)
                ST_IDLE: begin
                    if (pend_next != 6'd0) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    sreg      <= {cur_word[30:0], 1'b0};
                    vco_sdata <= cur_word[31];
                    bit_cnt   <= '0;
                    div_cnt   <= '0;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (!vco_sclk) begin
                            vco_sclk <= 1'b1;
                        end else begin
                            vco_sclk <= 1'b0;
                            if (bit_cnt == 5'd31) begin
                                vco_sdata <= 1'b0;
                                state     <= ST_LE_SETUP;
                            end else begin
                                bit_cnt   <= bit_cnt + 1'b1;
                                vco_sdata <= sreg[31];
                                sreg      <= {sreg[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LE_SETUP: begin
                    if (div_end) begin
                        div_cnt    <= '0;
                        vco_le     <= 1'b1;
                        load_count <= load_count + 1'b1;
                        state      <= ST_LE_PULSE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LE_PULSE: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        vco_le  <= 1'b0;
                        state   <= ST_GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (pend_next != 6'd0) begin
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VCO_LOCK_DETECT_EN
    logic unlock_pulse;

    vco_lock_filter #(
        .LOCK_CNT     (LOCK_CNT)
    ) u_lock (
        .clock        (clock),
        .reset        (reset),
        .vco_muxout   (vco_muxout),
        .locked       (locked),
        .unlock_pulse (unlock_pulse)
    );

    // loss of lock is remembered until software clears it
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sticky_unlock <= 1'b0;
        else if (unlock_pulse)
            sticky_unlock <= 1'b1;
        else if (ctrl_hit && serial_data[31])
            sticky_unlock <= 1'b0;
    end
`else
    logic        unused_muxout;
    logic [31:0] unused_lock_cnt;
    assign unused_muxout   = vco_muxout;
    assign unused_lock_cnt = 32'(LOCK_CNT);
    assign locked          = 1'b0;
    assign sticky_unlock   = 1'b0;
`endif

    assign status = {15'd0, busy, sticky_unlock, locked,
                     load_count, pending};

endmodule

// File: tb/tb_adf4350_loader.sv
// Self-checking bench for adf4350_loader: decodes the SPI bus
// into words and compares them with a shadow/queue model.
module tb_adf4350_loader;

    localparam int unsigned CD   = 4;
    localparam int unsigned LCNT = 1024;
    localparam logic [6:0]  BASE = 7'd96;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        serial_strobe = 1'b0;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        vco_muxout = 1'b0;
    logic        vco_sclk;
    logic        vco_sdata;
    logic        vco_le;
    logic        busy;
    logic        locked;
    logic [31:0] status;

    adf4350_loader #(
        .BASE_ADDR     (BASE),
        .CLK_DIV       (CD),
        .LOCK_CNT      (LCNT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .vco_muxout    (vco_muxout),
        .vco_sclk      (vco_sclk),
        .vco_sdata     (vco_sdata),
        .vco_le        (vco_le),
        .busy          (busy),
        .locked        (locked),
        .status        (status)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // bus monitor
    logic        p_sclk = 1'b0;
    logic        p_sdata = 1'b0;
    logic        p_le = 1'b0;
    logic        p_busy = 1'b0;
    int          bits = 0;
    logic [31:0] word = '0;
    int          le_cnt = 0;
    int          first_rise = -1;
    int          busy_fall = -1;
    int          last_rise = -1000;
    int          last_fall = -1000;
    int          last_chg = -1000;
    logic [31:0] obs_q[$];

    always @(negedge clock) begin
        if (reset) begin
            bits = 0;
            word = '0;
        end else begin
            if (vco_sdata !== p_sdata) begin
                chk("sdata_hold", 32'(cyc - last_rise >= CD), 1);
                last_chg = cyc;
            end
            if (vco_sclk && !p_sclk) begin
                chk("sdata_setup", 32'(cyc - last_chg >= CD), 1);
                word = {word[30:0], vco_sdata};
                bits++;
                last_rise = cyc;
                if (first_rise < 0) first_rise = cyc;
            end
            if (!vco_sclk && p_sclk) last_fall = cyc;
            if (vco_le && !p_le) begin
                chk("bits_per_word", 32'(bits), 32);
                chk("le_after_fall", 32'(cyc - last_fall >= CD), 1);
                obs_q.push_back(word);
                le_cnt++;
                bits = 0;
            end
            if (p_busy && !busy) busy_fall = cyc;
        end
        p_sclk  = vco_sclk;
        p_sdata = vco_sdata;
        p_le    = vco_le;
        p_busy  = busy;
    end

    // reference model
    logic [31:0] m_sh [6];
    logic [7:0]  m_lc = '0;
    logic [31:0] exp_q[$];
    int          cyc_strobe = 0;

    function automatic logic [31:0] exp_status();
        return {15'd0, 1'b0, 2'b00, m_lc, 6'd0};
    endfunction

    task automatic expect_mask(input logic [5:0] m);
        for (int i = 5; i >= 0; i--)
            if (m[i]) begin
                exp_q.push_back(m_sh[i]);
                m_lc++;
            end
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d,
                      input int ncyc);
        @(posedge clock);
        #1;
        serial_strobe = 1'b1;
        serial_addr   = a;
        serial_data   = d;
        cyc_strobe    = cyc;
        repeat (ncyc) @(posedge clock);
        #1;
        serial_strobe = 1'b0;
    endtask

    task automatic wr_shadow(input int k, input logic [31:0] d);
        m_sh[k] = {d[31:3], 3'(k)};
        wr(BASE + 7'(k), d, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("idle_wait", 32'(n < 3000), 1);
        repeat (4) @(negedge clock);
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_word"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int le0;
        int n;
        logic [31:0] oldw;
        logic [31:0] neww;
        logic [5:0]  m;

        for (int i = 0; i < 6; i++) m_sh[i] = '0;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_status", status, 32'd0);
        chk("rst_sclk", 32'(vco_sclk), 0);
        chk("rst_sdata", 32'(vco_sdata), 0);
        chk("rst_le", 32'(vco_le), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_locked", 32'(locked), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // R0 single load with latency and duration
        wr_shadow(0, 32'h00A5_5A28);
        first_rise = -1;
        le0 = le_cnt;
        expect_mask(6'h01);
        wr(BASE + 7'd6, 32'h1, 1);
        c = cyc_strobe;
        chk("busy_rise", 32'(busy), 1);
        wait_idle();
        chk("first_sclk_rise", 32'(first_rise), 32'(c + 2 + CD));
        chk("busy_fall", 32'(busy_fall), 32'(c + 2 + 67 * CD));
        chk("le_pulses", 32'(le_cnt - le0), 1);
        check_words("r0");
        chk("r0_status", status, exp_status());

        // full sequence R5..R0
        for (int k = 0; k < 6; k++) wr_shadow(k, $urandom);
        expect_mask(6'h3F);
        wr(BASE + 7'd6, 32'h3F, 1);
        wait_idle();
        check_words("full");
        chk("full_status", status, exp_status());

        // random masks and data
        for (int it = 0; it < 4; it++) begin
            wr_shadow($urandom_range(0, 5), $urandom);
            m = 6'($urandom_range(1, 63));
            expect_mask(m);
            wr(BASE + 7'd6, {26'($urandom), m}
                            & 32'h7FFF_FFFF, 1);
            wait_idle();
            check_words("rand");
            chk("rand_status", status, exp_status());
        end

        // in-flight isolation and re-queue of R3
        oldw = $urandom;
        neww = $urandom;
        wr_shadow(3, oldw);
        expect_mask(6'h08);
        wr(BASE + 7'd6, 32'h08, 1);
        repeat (40) @(negedge clock);
        wr_shadow(3, neww);
        expect_mask(6'h08);
        wr(BASE + 7'd6, 32'h08, 1);
        wait_idle();
        check_words("requeue");

        // command arriving in the LOAD cycle re-queues
        expect_mask(6'h08);
        expect_mask(6'h08);
        wr(BASE + 7'd6, 32'h08, 2);
        wait_idle();
        check_words("same_cycle");
        chk("same_status", status, exp_status());

        // reset during bit 17
        for (int k = 0; k < 6; k++) wr_shadow(k, $urandom);
        wr(BASE + 7'd6, 32'h3F, 1);
        n = 0;
        while (bits < 17 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("bit17_wait", 32'(n < 2000), 1);
        le0 = le_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_sclk", 32'(vco_sclk), 0);
        chk("midrst_sdata", 32'(vco_sdata), 0);
        chk("midrst_le", 32'(vco_le), 0);
        chk("midrst_status", status, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) m_sh[k] = '0;
        m_lc = '0;
        exp_q.delete();
        repeat (300) @(negedge clock);
        chk("midrst_no_le", 32'(le_cnt - le0), 0);
        chk("midrst_busy", 32'(busy), 0);
        check_words("midrst");
        expect_mask(6'h01);
        wr(BASE + 7'd6, 32'h01, 1);
        wait_idle();
        check_words("post_rst");
        chk("post_rst_status", status, exp_status());

`ifdef VCO_LOCK_DETECT_EN
        // lock qualification and sticky unlock
        @(posedge clock);
        #1;
        vco_muxout = 1'b1;
        repeat (LCNT) @(posedge clock);
        #1;
        chk("lock_early", 32'(locked), 0);
        repeat (3) @(posedge clock);
        #1;
        chk("lock_up", 32'(locked), 1);
        chk("lock_stat14", 32'(status[14]), 1);
        vco_muxout = 1'b0;
        @(posedge clock);
        #1;
        vco_muxout = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("lock_down", 32'(locked), 0);
        chk("sticky_set", 32'(status[15]), 1);
        vco_muxout = 1'b0;
        wr(BASE + 7'd6, 32'h8000_0000, 1);
        repeat (2) @(negedge clock);
        chk("sticky_clr", 32'(status[15]), 0);
        chk("sticky_clr_busy", 32'(busy), 0);
`else
        // muxout has no effect
        for (int i = 0; i < 48; i++) begin
            @(posedge clock);
            #1;
            vco_muxout = ($urandom_range(0, 3) != 0);
            if (i % 8 == 7) begin
                chk("nolock_locked", 32'(locked), 0);
                chk("nolock_stat", 32'(status[15:14]), 0);
            end
        end
        vco_muxout = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
